// File: rtl/lightgun_pkg.sv
// -----------------------------------------------------------------------------
// lightgun_pkg
// Shared types and constants for the light-gun H-counter latch.
//   th_state_e : per-port TH pin filter state (idle / armed)
//   HC_W       : width of the VDP horizontal pixel counter
//   PORT_A/B   : controller port indices
//   hc_scale() : trims a captured counter by a latency offset and drops the
//                pixel LSB to form the 8-bit H-counter read value
// -----------------------------------------------------------------------------
package lightgun_pkg;

    localparam int HC_W   = 9;
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    typedef enum logic [0:0] {
        TH_IDLE  = 1'b0,
        TH_ARMED = 1'b1
    } th_state_e;

    // Subtraction wraps modulo 512; the read value is bits [8:1] of the result.
    function automatic logic [7:0] hc_scale(input logic [HC_W-1:0] cap,
                                            input logic [HC_W-1:0] comp);
        logic [HC_W-1:0] diff;
        diff = cap - comp;
        return diff[HC_W-1:1];
    endfunction

endpackage

// File: rtl/th_edge_filter.sv
// -----------------------------------------------------------------------------
// th_edge_filter
// One controller port's TH sensing path.
//   - Synchronises the external TH pin (chain preset high).
//   - Pin path (th_dir=1): a synced 1->0 edge captures HCNT as a candidate and
//     arms a deglitch counter; the candidate commits once the pin has stayed low
//     for DEGLITCH pixel-clock-enable samples. Pin rising or direction change
//     while armed discards the candidate.
//   - Software path (th_dir=0): a falling edge of the effective level commits
//     the live HCNT immediately.
// Ports
//   clk, reset : system clock, synchronous active-high reset
//   ce_pix     : pixel clock enable
//   hcnt       : VDP horizontal pixel counter
//   th_in      : TH pin level from the gun (low = light seen)
//   th_dir     : 1 = TH is an input, 0 = TH driven by software
//   th_out     : software TH output level
//   commit     : one-CLK strobe, a latch value is presented on cand
//   cand       : 9-bit captured counter to latch when commit is high
//   level      : registered effective TH level
// -----------------------------------------------------------------------------
module th_edge_filter
    import lightgun_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEGLITCH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_pix,
    input  logic [HC_W-1:0] hcnt,
    input  logic            th_in,
    input  logic            th_dir,
    input  logic            th_out,
    output logic            commit,
    output logic [HC_W-1:0] cand,
    output logic            level
);

    localparam logic [7:0] DEGLITCH_C = 8'(DEGLITCH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pin_prev_q, pin_prev_d;
    th_state_e              state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [HC_W-1:0]        cand_q, cand_d;
    logic                   level_q, level_d;

    logic pin_s;
    logic pin_fall;
    logic pin_commit;
    logic sw_commit;

    // Synchroniser shift, edge history and effective level selection.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], th_in};
        pin_s      = sync_q[SYNC_STAGES-1];
        pin_prev_d = pin_s;
        pin_fall   = pin_prev_q & ~pin_s;
        level_d    = th_dir ? pin_s : th_out;
        // Falling effective edge while software owns the line. A DIR 1->0
        // switch with th_out high is a rising edge and so never latches.
        sw_commit  = ~th_dir & level_q & ~th_out;
    end

    // Idle/armed filter: next state, deglitch count and candidate capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        pin_commit = 1'b0;
        case (state_q)
            TH_IDLE: begin
                if (th_dir && pin_fall) begin
                    cand_d  = hcnt;
                    cnt_d   = 8'd0;
                    state_d = TH_ARMED;
                end else begin
                    state_d = TH_IDLE;
                end
            end
            TH_ARMED: begin
                if (!th_dir || pin_s) begin
                    // Pin released or direction changed: drop the candidate.
                    state_d = TH_IDLE;
                end else if (cnt_q == DEGLITCH_C) begin
                    // Checked before counting so DEGLITCH=0 commits on the
                    // first armed cycle regardless of ce_pix.
                    pin_commit = 1'b1;
                    state_d    = TH_IDLE;
                end else if (ce_pix) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = TH_IDLE;
            end
        endcase
    end

    // Filter state registers; synchroniser and level preset high on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= {SYNC_STAGES{1'b1}};
            pin_prev_q <= 1'b1;
            state_q    <= TH_IDLE;
            cnt_q      <= 8'd0;
            cand_q     <= {HC_W{1'b0}};
            level_q    <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            pin_prev_q <= pin_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            level_q    <= level_d;
        end
    end

    // pin_commit needs th_dir=1 and sw_commit needs th_dir=0: never both.
    assign commit = pin_commit | sw_commit;
    assign cand   = sw_commit ? hcnt : cand_q;
    assign level  = level_q;

endmodule

// File: rtl/lightgun_hcount_latch.sv
// -----------------------------------------------------------------------------
// lightgun_hcount_latch
// Console-side light-gun receiver for ports A and B. Latches the VDP
// horizontal counter on a qualified TH falling edge and presents it as the
// 8-bit H-counter read, plus the effective TH levels for the I/O port read.
// Ports
//   CLK, RESET        : system clock, synchronous active-high reset
//   CE_PIX            : pixel clock enable
//   HCNT[8:0]         : VDP horizontal pixel counter
//   TH_A_IN, TH_B_IN  : TH pin levels from the guns
//   TH_A_DIR, TH_B_DIR: 1 = TH is an input
//   TH_A_OUT, TH_B_OUT: software TH output levels
//   RD_HC             : one-CLK strobe, CPU read of the H counter
//   HC_OUT[7:0]       : latched H counter, (capture - HC_COMP)[8:1]
//   HC_LATCHED        : a latch occurred since the last RD_HC or reset
//   TH_LEVEL[1:0]     : {B, A} effective TH levels
// -----------------------------------------------------------------------------
module lightgun_hcount_latch
    import lightgun_pkg::*;
#(
    parameter int              SYNC_STAGES = 2,
    parameter int              DEGLITCH    = 4,
    parameter logic [HC_W-1:0] HC_COMP     = 9'd0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            CE_PIX,
    input  logic [HC_W-1:0] HCNT,
    input  logic            TH_A_IN,
    input  logic            TH_B_IN,
    input  logic            TH_A_DIR,
    input  logic            TH_B_DIR,
    input  logic            TH_A_OUT,
    input  logic            TH_B_OUT,
    input  logic            RD_HC,
    output logic [7:0]      HC_OUT,
    output logic            HC_LATCHED,
    output logic [1:0]      TH_LEVEL
);

    logic [1:0]      commit_s;
    logic [HC_W-1:0] cand_a_s, cand_b_s;
    logic [1:0]      level_s;

    logic [7:0] hc_q, hc_d;
    logic       latched_q, latched_d;

    th_edge_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEGLITCH    (DEGLITCH)
    ) u_filt_a (
        .clk    (CLK),
        .reset  (RESET),
        .ce_pix (CE_PIX),
        .hcnt   (HCNT),
        .th_in  (TH_A_IN),
        .th_dir (TH_A_DIR),
        .th_out (TH_A_OUT),
        .commit (commit_s[PORT_A]),
        .cand   (cand_a_s),
        .level  (level_s[PORT_A])
    );

    th_edge_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEGLITCH    (DEGLITCH)
    ) u_filt_b (
        .clk    (CLK),
        .reset  (RESET),
        .ce_pix (CE_PIX),
        .hcnt   (HCNT),
        .th_in  (TH_B_IN),
        .th_dir (TH_B_DIR),
        .th_out (TH_B_OUT),
        .commit (commit_s[PORT_B]),
        .cand   (cand_b_s),
        .level  (level_s[PORT_B])
    );

    // Latch update: port A has priority; any commit overrides a read clear.
    always_comb begin
        hc_d      = hc_q;
        latched_d = latched_q;
        if (commit_s[PORT_A]) begin
            hc_d      = hc_scale(cand_a_s, HC_COMP);
            latched_d = 1'b1;
        end else if (commit_s[PORT_B]) begin
            hc_d      = hc_scale(cand_b_s, HC_COMP);
            latched_d = 1'b1;
        end else if (RD_HC) begin
            latched_d = 1'b0;
        end else begin
            latched_d = latched_q;
        end
    end

    // H-counter latch and latched flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hc_q      <= 8'd0;
            latched_q <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            latched_q <= latched_d;
        end
    end

    assign HC_OUT     = hc_q;
    assign HC_LATCHED = latched_q;
    // Levels are already registered inside each filter.
    assign TH_LEVEL   = {level_s[PORT_B], level_s[PORT_A]};

endmodule

// File: tb/tb_lightgun_hcount_latch.sv
// -----------------------------------------------------------------------------
// tb_lightgun_hcount_latch
// Directed bench. dut uses DEGLITCH=4, HC_COMP=0; dut2 shares all inputs and
// uses DEGLITCH=0, HC_COMP=4 for the wrap and zero-deglitch cases.
// -----------------------------------------------------------------------------
module tb_lightgun_hcount_latch;
    import lightgun_pkg::*;

    logic       clk;
    logic       reset;
    logic       ce_pix;
    logic [8:0] hcnt;
    logic       th_a_in, th_b_in, th_a_dir, th_b_dir, th_a_out, th_b_out;
    logic       rd_hc;
    logic [7:0] hc_out, hc_out2;
    logic       hc_latched, hc_latched2;
    logic [1:0] th_level, th_level2;

    int errors = 0;
    int checks = 0;

    lightgun_hcount_latch #(
        .SYNC_STAGES (2),
        .DEGLITCH    (4),
        .HC_COMP     (9'd0)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .CE_PIX     (ce_pix),
        .HCNT       (hcnt),
        .TH_A_IN    (th_a_in),
        .TH_B_IN    (th_b_in),
        .TH_A_DIR   (th_a_dir),
        .TH_B_DIR   (th_b_dir),
        .TH_A_OUT   (th_a_out),
        .TH_B_OUT   (th_b_out),
        .RD_HC      (rd_hc),
        .HC_OUT     (hc_out),
        .HC_LATCHED (hc_latched),
        .TH_LEVEL   (th_level)
    );

    lightgun_hcount_latch #(
        .SYNC_STAGES (2),
        .DEGLITCH    (0),
        .HC_COMP     (9'd4)
    ) dut2 (
        .CLK        (clk),
        .RESET      (reset),
        .CE_PIX     (ce_pix),
        .HCNT       (hcnt),
        .TH_A_IN    (th_a_in),
        .TH_B_IN    (th_b_in),
        .TH_A_DIR   (th_a_dir),
        .TH_B_DIR   (th_b_dir),
        .TH_A_OUT   (th_a_out),
        .TH_B_OUT   (th_b_out),
        .RD_HC      (rd_hc),
        .HC_OUT     (hc_out2),
        .HC_LATCHED (hc_latched2),
        .TH_LEVEL   (th_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CLK with CE_PIX high, then CE_PIX back low.
    task automatic pulse();
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ce_pix   = 1'b0;
        hcnt     = 9'd0;
        th_a_in  = 1'b1;
        th_b_in  = 1'b1;
        th_a_dir = 1'b1;
        th_b_dir = 1'b0;
        th_a_out = 1'b1;
        th_b_out = 1'b1;
        rd_hc    = 1'b0;

        // ---- 1: reset, pins toggling under reset cause no latch
        tick(); tick();
        chk("rst_hc", 16'(hc_out), 16'd0);
        chk("rst_lat", 16'(hc_latched), 16'd0);
        chk("rst_lvl", 16'(th_level), 16'd3);
        th_a_in = 1'b0; th_b_in = 1'b0; th_b_out = 1'b0; ce_pix = 1'b1;
        tick(); tick();
        th_a_in = 1'b1; th_b_in = 1'b1; th_b_out = 1'b1; ce_pix = 1'b0;
        tick(); tick(); tick();
        chk("rst_hold_lat", 16'(hc_latched), 16'd0);
        chk("rst_hold_lvl2", 16'(th_level2), 16'd3);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_hc", 16'(hc_out), 16'd0);
        chk("post_rst_lat", 16'(hc_latched), 16'd0);
        chk("post_rst_lvl", 16'(th_level), 16'd3);

        // ---- 2: pin latch at HCNT=200, DEGLITCH=4
        hcnt = 9'd200;
        th_a_in = 1'b0;
        tick(); tick(); tick();
        chk("pin_lvl_a_low", 16'(th_level), 16'd2);
        for (int i = 0; i < 3; i++) begin
            pulse();
            tick();
        end
        pulse();
        chk("pin_lat_not_yet", 16'(hc_latched), 16'd0);
        tick();
        chk("pin_lat", 16'(hc_latched), 16'd1);
        chk("pin_hc", 16'(hc_out), 16'd100);
        pulse(); tick(); pulse(); tick();
        chk("pin_hc_hold", 16'(hc_out), 16'd100);
        chk("zero_dg_hc2", 16'(hc_out2), 16'd98);

        // RD_HC clears the flag only
        rd_hc = 1'b1;
        tick();
        rd_hc = 1'b0;
        chk("rd_lat", 16'(hc_latched), 16'd0);
        chk("rd_hc_keep", 16'(hc_out), 16'd100);

        // ---- 3: glitch, low for 2 CE_PIX then high
        th_a_in = 1'b1;
        tick(); tick(); tick(); tick();
        hcnt = 9'd50;
        th_a_in = 1'b0;
        tick(); tick(); tick();
        pulse(); tick(); pulse(); tick();
        th_a_in = 1'b1;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            pulse();
            tick();
        end
        chk("glitch_lat", 16'(hc_latched), 16'd0);
        chk("glitch_hc", 16'(hc_out), 16'd100);
        chk("glitch_idle", 16'(dut.u_filt_a.state_q), 16'(TH_IDLE));

        // ---- 4: software latch on port B at HCNT=341
        hcnt = 9'd341;
        th_b_out = 1'b0;
        tick();
        chk("sw_hc", 16'(hc_out), 16'd170);
        chk("sw_lat", 16'(hc_latched), 16'd1);
        chk("sw_lvl", 16'(th_level), 16'd1);
        rd_hc = 1'b1;
        tick();
        rd_hc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            th_b_in = ~th_b_in;
            pulse();
            tick();
        end
        chk("sw_pin_ignored_lat", 16'(hc_latched), 16'd0);
        chk("sw_pin_ignored_hc", 16'(hc_out), 16'd170);

        // ---- 5: A and B commit together with RD_HC
        th_b_out = 1'b1;
        tick();
        hcnt = 9'd60;
        th_a_in = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            pulse();
            tick();
        end
        pulse();
        hcnt = 9'd90;
        th_b_out = 1'b0;
        rd_hc = 1'b1;
        tick();
        chk("coll_hc", 16'(hc_out), 16'd30);
        chk("coll_lat", 16'(hc_latched), 16'd1);
        tick();
        rd_hc = 1'b0;
        chk("coll_rd_lat", 16'(hc_latched), 16'd0);
        chk("coll_rd_hc", 16'(hc_out), 16'd30);

        // ---- 6: wrap (dut2, cand=2, HC_COMP=4) and DIR abort (dut)
        th_a_in = 1'b1;
        th_b_out = 1'b1;
        tick(); tick(); tick(); tick();
        hcnt = 9'd2;
        th_a_in = 1'b0;
        tick(); tick(); tick();
        tick();
        chk("wrap_hc2", 16'(hc_out2), 16'hFF);
        chk("wrap_lat2", 16'(hc_latched2), 16'd1);
        th_a_dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse();
            tick();
        end
        chk("abort_lat", 16'(hc_latched), 16'd0);
        chk("abort_hc", 16'(hc_out), 16'd30);
        chk("abort_lvl", 16'(th_level), 16'd3);
        th_a_dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse();
            tick();
        end
        chk("redir_no_edge_lat", 16'(hc_latched), 16'd0);

        // ---- 7: reset while armed aborts
        th_a_in = 1'b1;
        tick(); tick(); tick(); tick();
        hcnt = 9'd120;
        th_a_in = 1'b0;
        tick(); tick(); tick();
        pulse(); tick(); pulse(); tick();
        reset = 1'b1;
        tick();
        chk("rst_armed_hc", 16'(hc_out), 16'd0);
        th_a_in = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse();
            tick();
        end
        chk("rst_armed_lat", 16'(hc_latched), 16'd0);
        chk("rst_armed_hc_hold", 16'(hc_out), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
